// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions.
//   SEG_TABLE : hex nibble -> {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, Dp off (1)
//   SEG_OFF   : all segments and decimal point dark
//   clog2     : ceiling log2, used for index widths
package ssd_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'b0000_0011,  // 0
    8'b1001_1111,  // 1
    8'b0010_0101,  // 2
    8'b0000_1101,  // 3
    8'b1001_1001,  // 4
    8'b0100_1001,  // 5
    8'b0100_0001,  // 6
    8'b0001_1111,  // 7
    8'b0000_0001,  // 8
    8'b0000_1001,  // 9
    8'b0001_0001,  // A
    8'b1100_0001,  // B
    8'b0110_0011,  // C
    8'b1000_0101,  // D
    8'b0110_0001,  // E
    8'b0111_0001   // F
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_ssd.sv
// Combinational hex nibble to seven-segment decoder.
//   hex_in : nibble to display
//   dp_on  : 1 = decimal point lit
//   seg_n  : {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
module hex_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] hex_in,
  input  logic       dp_on,
  output logic [7:0] seg_n
);

  logic [7:0] table_seg;

  always_comb begin
    table_seg = SEG_TABLE[hex_in];
    seg_n     = {table_seg[7:1], ~dp_on};
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed, double-buffered seven-segment scan driver for NUM_DIGITS digits.
//   ClkPort    : system clock
//   Reset      : asynchronous active-low reset
//   digits_in  : hex nibbles, digit d = digits_in[4d+3:4d], d = NUM_DIGITS-1 leftmost
//   dp_in      : per-digit decimal point enable
//   blank_in   : per-digit blank
//   load       : strobe capturing digits_in/dp_in/blank_in into the pending buffer
//   An         : anodes, active-low
//   Cathodes   : {Ca..Cg,Dp}, active-low
//   scan_idx   : current slot (slot k shows digit NUM_DIGITS-1-k)
//   frame_done : one-cycle pulse at frame wrap
// Build option: define SSD_LZS_EN for leading-zero suppression.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV_W = 18,
  parameter int BLANK_CYCLES  = 16
) (
  input  logic                         ClkPort,
  input  logic                         Reset,
  input  logic [4*NUM_DIGITS-1:0]      digits_in,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  input  logic [NUM_DIGITS-1:0]        blank_in,
  input  logic                         load,
  output logic [NUM_DIGITS-1:0]        An,
  output logic [7:0]                   Cathodes,
  output logic [clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                         frame_done
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REFRESH_DIV_W-1:0] BLANK_CNT = REFRESH_DIV_W'(BLANK_CYCLES);

  logic [REFRESH_DIV_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0][3:0]     pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]          pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]          pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0][3:0]     act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]          act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]          act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]          an_q, an_d;
  logic [7:0]                     cath_q, cath_d;

  logic                           slot_end;
  logic                           frame_end;
  logic [IDX_W-1:0]               disp_sel;
  logic                           lit;
  logic [7:0]                     seg_n;
  logic [NUM_DIGITS-1:0]          lzs_mask;

  // Leftmost slot shows the highest digit.
  assign disp_sel = LAST_IDX - idx_q;

  hex_to_ssd u_dec (
    .hex_in (act_digits_q[disp_sel]),
    .dp_on  (act_dp_q[disp_sel]),
    .seg_n  (seg_n)
  );

`ifdef SSD_LZS_EN
  logic lead;

  // Computed on the data about to become active; digit 0 is never suppressed.
  always_comb begin
    lzs_mask = '0;
    lead     = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      if (lead && (pend_digits_d[NUM_DIGITS-1-k] == 4'h0)) begin
        lzs_mask[NUM_DIGITS-1-k] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  always_comb begin
    lzs_mask = '0;
  end
`endif

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    slot_end  = &cnt_q;
    frame_end = slot_end && (idx_q == LAST_IDX);

    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    pend_digits_d = load ? digits_in : pend_digits_q;
    pend_dp_d     = load ? dp_in     : pend_dp_q;
    pend_blank_d  = load ? blank_in  : pend_blank_q;

    // Copying from the *_d pending values gives the same-cycle load bypass.
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (frame_end) begin
      act_digits_d = pend_digits_d;
      act_dp_d     = pend_dp_d;
      act_blank_d  = pend_blank_d | lzs_mask;
    end

    frame_done_d = frame_end;

    lit    = (cnt_q >= BLANK_CNT) && !act_blank_q[disp_sel];
    an_d   = '1;
    cath_d = SEG_OFF;
    if (lit) begin
      an_d[disp_sel] = 1'b0;
      cath_d         = seg_n;
    end
  end

  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      frame_done_q  <= 1'b0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '0;
      an_q          <= '1;
      cath_q        <= SEG_OFF;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_done_q  <= frame_done_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      an_q          <= an_d;
      cath_q        <= cath_d;
    end
  end

  assign An         = an_q;
  assign Cathodes   = cath_q;
  assign scan_idx   = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (NUM_DIGITS=4, REFRESH_DIV_W=3,
// BLANK_CYCLES=2: 8-clock slots, 32-clock frames).
module tb_ssd_scan_driver;

  localparam int ND = 4;
  localparam int RW = 3;
  localparam int BC = 2;

  logic          ClkPort   = 1'b0;
  logic          Reset     = 1'b0;
  logic [15:0]   digits_in = '0;
  logic [3:0]    dp_in     = '0;
  logic [3:0]    blank_in  = '0;
  logic          load      = 1'b0;
  logic [3:0]    An;
  logic [7:0]    Cathodes;
  logic [1:0]    scan_idx;
  logic          frame_done;

  always #5 ClkPort = ~ClkPort;

  ssd_scan_driver #(
    .NUM_DIGITS    (ND),
    .REFRESH_DIV_W (RW),
    .BLANK_CYCLES  (BC)
  ) dut (
    .ClkPort    (ClkPort),
    .Reset      (Reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .An         (An),
    .Cathodes   (Cathodes),
    .scan_idx   (scan_idx),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] cath;
  } exp_t;

  // cath_slots lists slot 0 (leftmost digit) first; 8'hFF means a dark slot.
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [31:0] cath_slots;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[4];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_slots(input logic [31:0] cs);
    exp_t e;
    logic [3:0] one;
    for (int s = 0; s < 4; s++) begin
      one    = 4'b1000;
      e.cath = cs[31-8*s -: 8];
      e.an   = (e.cath == 8'hFF) ? 4'hF : ~(one >> s);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    digits_in = d;
    dp_in     = dp;
    blank_in  = bl;
    load      = 1'b1;
    @(negedge ClkPort);
    load      = 1'b0;
  endtask

  task automatic wait_frame_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge ClkPort);
      if (frame_done) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL frame_done_timeout: got no pulse within 200 cycles expected a pulse");
  endtask

  // Starts on the negedge right after a frame_done edge, ends on the next one.
  task automatic check_frame(input string tag);
    exp_t e;
    logic [3:0] an_e;
    logic [7:0] ca_e;
    for (int s = 0; s < 4; s++) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_queue_empty: got empty scoreboard expected entry for slot %0d", tag, s);
        e = '{an: 4'hF, cath: 8'hFF};
      end else begin
        e = exp_q.pop_front();
      end
      for (int c = 1; c <= 8; c++) begin
        @(negedge ClkPort);
        an_e = (c <= 2) ? 4'hF  : e.an;
        ca_e = (c <= 2) ? 8'hFF : e.cath;
        check($sformatf("%s_s%0d_c%0d_an_cath", tag, s, c), {20'd0, An, Cathodes}, {20'd0, an_e, ca_e});
        if (c < 8) check($sformatf("%s_s%0d_c%0d_idx", tag, s, c), {30'd0, scan_idx}, s);
        check($sformatf("%s_s%0d_c%0d_fdone", tag, s, c), {31'd0, frame_done},
              {31'd0, (s == 3 && c == 8)});
      end
    end
  endtask

  logic [3:0] prev_an0;
  logic [7:0] prev_ca0;

  initial begin
    vecs[0] = '{digits: 16'h12AF, dp: 4'b0000, blank: 4'b0000,
                cath_slots: {8'b1001_1111, 8'b0010_0101, 8'b0001_0001, 8'b0111_0001}};
    vecs[1] = '{digits: 16'h7650, dp: 4'b0001, blank: 4'b0010,
                cath_slots: {8'b0001_1111, 8'b0100_0001, 8'hFF, 8'b0000_0010}};
    vecs[2] = '{digits: 16'hBCDE, dp: 4'b1111, blank: 4'b0000,
                cath_slots: {8'b1100_0000, 8'b0110_0010, 8'b1000_0100, 8'b0110_0000}};
    vecs[3] = '{digits: 16'h3489, dp: 4'b0000, blank: 4'b0000,
                cath_slots: {8'b0000_1101, 8'b1001_1001, 8'b0000_0001, 8'b0000_1001}};

    // Reset state
    repeat (3) @(negedge ClkPort);
    check("reset_an", {28'd0, An}, 32'hF);
    check("reset_cath", {24'd0, Cathodes}, 32'hFF);
    check("reset_idx", {30'd0, scan_idx}, 0);
    check("reset_fdone", {31'd0, frame_done}, 0);

    // Run into slot 1 with zeroed buffers, then reset asynchronously mid-scan.
    Reset = 1'b1;
    repeat (13) @(negedge ClkPort);
    check("prereset_an", {28'd0, An}, 32'b1011);
    check("prereset_cath", {24'd0, Cathodes}, 32'b0000_0011);
    check("prereset_idx", {30'd0, scan_idx}, 1);
    #2 Reset = 1'b0;
    #1;
    check("async_reset_an", {28'd0, An}, 32'hF);
    check("async_reset_cath", {24'd0, Cathodes}, 32'hFF);
    check("async_reset_idx", {30'd0, scan_idx}, 0);
    check("async_reset_fdone", {31'd0, frame_done}, 0);
    @(negedge ClkPort);
    Reset = 1'b1;
    repeat (2) @(negedge ClkPort);
    check("release_blank_an", {28'd0, An}, 32'hF);
    @(negedge ClkPort);
    check("release_first_an", {28'd0, An}, 32'b0111);
    check("release_first_cath", {24'd0, Cathodes}, 32'b0000_0011);

    wait_frame_done();
`ifdef SSD_LZS_EN
    prev_an0 = 4'hF;
    prev_ca0 = 8'hFF;
`else
    prev_an0 = 4'b0111;
    prev_ca0 = 8'b0000_0011;
`endif

    // Table rows: load mid-frame, old data must persist until the wrap.
    for (int r = 0; r < 4; r++) begin
      drive_load(vecs[r].digits, vecs[r].dp, vecs[r].blank);
      push_slots(vecs[r].cath_slots);
      repeat (4) @(negedge ClkPort);
      check($sformatf("row%0d_no_tear", r), {20'd0, An, Cathodes}, {20'd0, prev_an0, prev_ca0});
      wait_frame_done();
      check_frame($sformatf("row%0d", r));
      prev_ca0 = vecs[r].cath_slots[31:24];
      prev_an0 = (prev_ca0 == 8'hFF) ? 4'hF : 4'b0111;
    end

    // Two loads in one frame: only the later one is shown.
    drive_load(16'h3333, 4'h0, 4'h0);
    repeat (10) @(negedge ClkPort);
    drive_load(16'h4444, 4'h0, 4'h0);
    push_slots({4{8'b1001_1001}});
    wait_frame_done();
    check_frame("double_load");

    // Load on the exact frame-boundary cycle is shown from the next slot 0.
    repeat (31) @(negedge ClkPort);
    digits_in = 16'h9999;
    dp_in     = 4'h0;
    blank_in  = 4'h0;
    load      = 1'b1;
    @(negedge ClkPort);
    load      = 1'b0;
    check("bypass_fdone", {31'd0, frame_done}, 1);
    push_slots({4{8'b0000_1001}});
    check_frame("bypass");

`ifdef SSD_LZS_EN
    drive_load(16'h0005, 4'h0, 4'h0);
    push_slots({8'hFF, 8'hFF, 8'hFF, 8'b0100_1001});
    wait_frame_done();
    check_frame("lzs_0005");
    drive_load(16'h0000, 4'h0, 4'h0);
    push_slots({8'hFF, 8'hFF, 8'hFF, 8'b0000_0011});
    wait_frame_done();
    check_frame("lzs_0000");
`endif

    // Reset with a pending load: the load is lost, buffers come back zeroed.
    drive_load(16'h5678, 4'hF, 4'h0);
    repeat (2) @(negedge ClkPort);
    #2 Reset = 1'b0;
    #1;
    check("reset2_an", {28'd0, An}, 32'hF);
    check("reset2_cath", {24'd0, Cathodes}, 32'hFF);
    @(negedge ClkPort);
    Reset = 1'b1;
    wait_frame_done();
`ifdef SSD_LZS_EN
    push_slots({8'hFF, 8'hFF, 8'hFF, 8'b0000_0011});
`else
    push_slots({4{8'b0000_0011}});
`endif
    check_frame("reset2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
